// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit unsigned multiply/divide unit with register-file write-back
// Optional divider datapath built when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [ADDR_W-1:0] Dest,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  Result,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              Write_Reg,
    output logic              div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [5:0]          cnt;
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   dest_q;

    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_next;
    logic                finish;
    logic [WIDTH-1:0]    fin_res;
    logic                fin_wr;
    logic                fin_dz;

    // Shift-add step: add multiplicand into the upper half on a set multiplier bit, then shift right with carry
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next = (2*WIDTH)'({mul_sum, acc[WIDTH-1:0]} >> 1);
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]      div_shift;
    logic                div_ge;
    logic [WIDTH-1:0]    div_sub;
    logic [2*WIDTH-1:0]  div_next;

    // Restoring step: {rem, quo} shifts left pulling in the next dividend bit; the 33-bit compare decides the quotient bit
    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end
`endif

    // Completion decision and the value to be written back on the DONE entry
    always_comb begin
        finish  = 1'b0;
        fin_res = '0;
        fin_wr  = (dest_q != '0);
        fin_dz  = 1'b0;
        if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
            if (b_q == '0) begin
                finish  = 1'b1;
                fin_res = op_q[0] ? a_q : {WIDTH{1'b1}};
                fin_dz  = 1'b1;
            end else begin
                finish  = (cnt == 6'd31);
                fin_res = op_q[0] ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
            end
`else
            finish = 1'b1;
            fin_wr = 1'b0;
`endif
        end else begin
            finish  = (cnt == 6'd31);
            fin_res = op_q[0] ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and registered write-back outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            dest_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
            W_Addr    <= '0;
            Write_Reg <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    Write_Reg <= 1'b0;
                    div_zero  <= 1'b0;
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        op_q   <= op;
                        dest_q <= Dest;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
                        acc <= div_next;
                        a_q <= a_q << 1;
`endif
                    end else begin
                        acc <= mul_next;
                        b_q <= b_q >> 1;
                    end
                    if (finish) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        Result    <= fin_res;
                        W_Addr    <= dest_q;
                        Write_Reg <= fin_wr;
                        div_zero  <= fin_dz;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    Write_Reg <= 1'b0;
                    div_zero  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  addr;
        logic        wr;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  w_addr;
    logic        write_reg;
    logic        div_zero;

    exp_t sb[$];
    int   passed;
    int   total;

    muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .A(a),
        .B(b),
        .Dest(dest),
        .busy(busy),
        .done(done),
        .Result(result),
        .W_Addr(w_addr),
        .Write_Reg(write_reg),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one operation from a negedge, wait for done, compare against the scoreboard head
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] d, input logic [31:0] er,
                          input int elat, input logic ewr, input logic edz, input bit poke);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        e = '{res: er, addr: d, wr: ewr, dz: edz};
        sb.push_back(e);
        op = o; a = av; b = bv; dest = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) lat = 60;
            else if (poke && lat == 10) begin
                start = 1'b1; op = ~o; a = 32'h1234_5678; b = 32'h0000_0055; dest = 5'd9;
            end
        end
        chk({tag, "_completed"}, seen, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            got = sb.pop_front();
            if (seen) begin
                chk({tag, "_latency"}, lat, elat);
                chk({tag, "_result"}, result, got.res);
                chk({tag, "_w_addr"}, w_addr, got.addr);
                chk({tag, "_write_reg"}, write_reg, got.wr);
                chk({tag, "_div_zero"}, div_zero, got.dz);
                chk({tag, "_busy_in_done"}, busy, 1'b1);
                @(negedge clk);
                chk({tag, "_done_pulse"}, done, 1'b0);
                chk({tag, "_wr_pulse"}, write_reg, 1'b0);
                chk({tag, "_busy_after"}, busy, 1'b0);
                chk({tag, "_result_hold"}, result, got.res);
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;
        int          bad;
        passed = 0;
        total  = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dest = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_w_addr", w_addr, 5'h0);
        chk("rst_write_reg", write_reg, 1'b0);
        chk("rst_div_zero", div_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 32, 1'b1, 1'b0, 1'b0);
        run_op("mulh_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 32, 1'b1, 1'b0, 1'b0);
        run_op("mull_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001, 32, 1'b1, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
        run_op("divq", 2'b10, 32'd100, 32'd7, 5'd7, 32'd14, 32, 1'b1, 1'b0, 1'b0);
        run_op("divr", 2'b11, 32'd100, 32'd7, 5'd8, 32'd2, 32, 1'b1, 1'b0, 1'b0);
        run_op("divq_big", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 5'd9, 32'h0FFF_FFFF, 32, 1'b1, 1'b0, 1'b0);
        run_op("divq_zero", 2'b10, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b1, 1'b1, 1'b0);
        run_op("divr_zero", 2'b11, 32'd5, 32'd0, 5'd11, 32'd5, 1, 1'b1, 1'b1, 1'b0);
`else
        run_op("divq_off", 2'b10, 32'd100, 32'd7, 5'd7, 32'd0, 1, 1'b0, 1'b0, 1'b0);
        run_op("divr_off", 2'b11, 32'd100, 32'd7, 5'd8, 32'd0, 1, 1'b0, 1'b0, 1'b0);
        run_op("divq_zero_off", 2'b10, 32'd5, 32'd0, 5'd10, 32'd0, 1, 1'b0, 1'b0, 1'b0);
`endif
        run_op("mul_poke", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 32, 1'b1, 1'b0, 1'b1);
        run_op("mul_dest0", 2'b00, 32'd9, 32'd9, 5'd0, 32'd81, 32, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            prod = {32'h0, ra} * {32'h0, rb};
            run_op("mul_rand_hi", 2'b01, ra, rb, 5'd12, prod[63:32], 32, 1'b1, 1'b0, 1'b0);
            run_op("mul_rand_lo", 2'b00, ra, rb, 5'd13, prod[31:0], 32, 1'b1, 1'b0, 1'b0);
        end

        op = 2'b00; a = 32'd3; b = 32'd5; dest = 5'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_write_reg", write_reg, 1'b0);
        chk("mid_rst_w_addr", w_addr, 5'h0);
        @(negedge clk);
        chk("rst_held_start_busy", busy, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || write_reg || busy) bad++;
        end
        chk("no_done_after_rst", bad, 0);
        run_op("mul_after_rst", 2'b01, 32'h8000_0000, 32'd4, 5'd31, 32'd2, 32, 1'b1, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
